calculator_core: RTL and testbench
==================================

CALCULATOR_CORE -- requirements
Module: calculator_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width; result width is 2*DATA_W.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port dat_a_in  input  DATA_W  operand A, unsigned.
REQ-005 SHALL have port dat_b_in  input  DATA_W  operand B, unsigned.
REQ-006 SHALL have port function_in  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-007 SHALL have port start_in  input  1  request; sampled only in IDLE.
REQ-008 SHALL have port out  output  2*DATA_W  registered result.
REQ-009 SHALL have port busy_out  output  1  high while state is EXEC.
REQ-010 SHALL have port done_out  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err_out  output  1  divide-by-zero flag.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-013 IDLE with start_in=1 at edge T SHALL capture dat_a_in, dat_b_in and function_in into internal registers, clear err_out and enter EXEC.
REQ-014 start_in SHALL be ignored in EXEC and DONE; operand inputs changing after T SHALL NOT affect the result.
REQ-015 ADD/SUB SHALL spend one cycle in EXEC; out is written at edge T+1.
REQ-016 MUL/DIV SHALL spend DATA_W cycles in EXEC; out is written at edge T+DATA_W.
REQ-017 On the edge that writes out, the FSM SHALL enter DONE; done_out=1 for exactly that one cycle; the next edge returns to IDLE.
REQ-018 ADD: out = zero-extended (DATA_W+1)-bit sum A+B.
REQ-019 SUB: out = A-B as a 2*DATA_W two's-complement value (sign-extended borrow).
REQ-020 MUL: out = full 2*DATA_W unsigned product, via iterative shift-add, one partial product per cycle.
REQ-021 DIV: restoring division, one quotient bit per cycle; out[DATA_W-1:0]=quotient, out[2*DATA_W-1:DATA_W]=remainder.
REQ-022 DIV with B=0 SHALL complete like ADD (one EXEC cycle), set out all ones and set err_out=1.
REQ-023 err_out SHALL hold until the next accepted start.
REQ-024 out SHALL hold its value between result writes; intermediate EXEC values SHALL NOT appear on out.
REQ-025 busy_out and done_out SHALL never be high in the same cycle.
REQ-026 A start_in held high continuously SHALL be accepted again on the first IDLE cycle after DONE.

Reset
REQ-027 rst_n low SHALL immediately, without a clock, force state IDLE, out=0, busy_out=0, done_out=0, err_out=0 and clear all iteration counters and partial registers.
REQ-028 Reset during EXEC SHALL abort the operation with no done_out pulse.
REQ-029 The first start SHALL be accepted on the first rising edge with rst_n high.

Verification (DATA_W=8)
REQ-030 ADD: A=0xFF, B=0xFF, start -> out=0x01FE one edge later; single done_out pulse; busy_out high for 1 cycle.
REQ-031 SUB: A=0x03, B=0x05 -> out=0xFFFE, err_out=0.
REQ-032 MUL: A=0xFF, B=0xFF -> busy_out high 8 cycles, then out=0xFE01 with done_out; toggling inputs and start_in during EXEC changes nothing.
REQ-033 DIV: A=200, B=7 -> after 8 cycles out=0x041C (quotient 28, remainder 4).
REQ-034 DIV by zero: A=0x12, B=0x00 -> one edge later out=0xFFFF, err_out=1; err_out clears on the next accepted start.
REQ-035 Reset mid-MUL, asserted after 4 EXEC cycles -> immediate out=0, busy_out=0, no done_out; the next ADD 1+1 returns 0x0002.

Source files
------------

// File: rtl/calculator_core.sv
// Multi-cycle integer calculator: single-cycle ADD/SUB, iterative shift-add MUL
// and restoring DIV, sequenced by an IDLE/EXEC/DONE controller.
module calculator_core #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     dat_a_in,
    input  logic [DATA_W-1:0]     dat_b_in,
    input  logic [1:0]            function_in,
    input  logic                  start_in,
    output logic [2*DATA_W-1:0]   out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  err_out
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    state_t state, state_next;
    op_t    op;

    // opa doubles as the DIV quotient shift register, opb as the MUL multiplier shifter
    logic [DATA_W-1:0]   opa, opb, rem;
    logic [2*DATA_W-1:0] mcand, acc;
    logic [CNT_W-1:0]    cnt;

    logic                last_step, div_zero, finish;
    logic [DATA_W:0]     sum, diff, trial;
    logic                ge;
    logic [DATA_W-1:0]   rem_next, quo_next;
    logic [DATA_W:0]     quo_shift;
    logic [DATA_W:0]     trial_sub;
    logic [2*DATA_W-1:0] acc_next, result;

    always_comb begin
        last_step = (cnt == CNT_W'(DATA_W - 1));
        div_zero  = (opb == '0);

        sum  = {1'b0, opa} + {1'b0, opb};
        diff = {1'b0, opa} - {1'b0, opb};

        acc_next = acc + (opb[0] ? mcand : '0);

        trial     = {rem, opa[DATA_W-1]};
        ge        = (trial >= {1'b0, opb});
        trial_sub = trial - {1'b0, opb};
        rem_next  = ge ? trial_sub[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_shift = {opa, ge};
        quo_next  = quo_shift[DATA_W-1:0];

        finish = 1'b0;
        result = '0;
        case (op)
            OP_ADD: begin
                finish = 1'b1;
                result = (2*DATA_W)'(sum);
            end
            OP_SUB: begin
                finish = 1'b1;
                result = {{(DATA_W-1){diff[DATA_W]}}, diff};
            end
            OP_MUL: begin
                finish = last_step;
                result = acc_next;
            end
            OP_DIV: begin
                finish = div_zero || last_step;
                result = div_zero ? '1 : {rem_next, quo_next};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy_out   = 1'b0;
        done_out   = 1'b0;
        case (state)
            IDLE: if (start_in) state_next = EXEC;
            EXEC: begin
                busy_out = 1'b1;
                if (finish) state_next = DONE;
            end
            DONE: begin
                done_out   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op      <= OP_ADD;
            opa     <= '0;
            opb     <= '0;
            rem     <= '0;
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            out     <= '0;
            err_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_in) begin
                    op      <= op_t'(function_in);
                    opa     <= dat_a_in;
                    opb     <= dat_b_in;
                    rem     <= '0;
                    mcand   <= (2*DATA_W)'(dat_a_in);
                    acc     <= '0;
                    cnt     <= '0;
                    err_out <= 1'b0;
                end
                EXEC: if (finish) begin
                    out     <= result;
                    err_out <= (op == OP_DIV) && div_zero;
                end else begin
                    cnt <= cnt + 1'b1;
                    case (op)
                        OP_MUL: begin
                            acc   <= acc_next;
                            mcand <= mcand << 1;
                            opb   <= opb >> 1;
                        end
                        OP_DIV: begin
                            opa <= quo_next;
                            rem <= rem_next;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calculator_core.sv
// Directed, table-driven bench for calculator_core (DATA_W=8) with hand-written
// sequences for input toggling, held start and reset during EXEC.
module tb_calculator_core;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [W-1:0]   a = '0, b = '0;
    logic [1:0]     fn = '0;
    logic           start = 1'b0;
    logic [2*W-1:0] out;
    logic           busy, done, err;

    int checks = 0;
    int failures = 0;

    calculator_core #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dat_a_in   (a),
        .dat_b_in   (b),
        .function_in(fn),
        .start_in   (start),
        .out        (out),
        .busy_out   (busy),
        .done_out   (done),
        .err_out    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [1:0]   vfn;
        logic [15:0]  exp_out;
        logic         exp_err;
        int           exp_busy;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns on the idle negedge after the done pulse.
    task automatic wait_result(input string name, input logic [15:0] exp_out, input logic exp_err,
                               input int exp_busy, input bit toggle, output int cycles);
        logic [15:0] held;
        int nbusy;
        bit seen;
        held = out;
        nbusy = 0;
        seen = 0;
        cycles = 0;
        while (!seen && cycles < 40) begin
            @(negedge clk);
            cycles++;
            chk({name, " busy_done_overlap"}, 32'(busy & done), 0);
            if (busy) begin
                nbusy++;
                chk({name, " out_hold"}, 32'(out), 32'(held));
                if (toggle) begin
                    a = W'($urandom);
                    b = W'($urandom);
                    fn = 2'($urandom);
                    start = 1'($urandom);
                end
            end
            if (done) begin
                seen = 1;
                if (toggle) start = 1'b1;
            end
        end
        chk({name, " done_seen"}, 32'(seen), 1);
        chk({name, " out"}, 32'(out), 32'(exp_out));
        chk({name, " err"}, 32'(err), 32'(exp_err));
        chk({name, " busy_cycles"}, nbusy, exp_busy);
        @(negedge clk);
        chk({name, " done_one_pulse"}, 32'(done), 0);
        chk({name, " err_hold"}, 32'(err), 32'(exp_err));
        chk({name, " out_after"}, 32'(out), 32'(exp_out));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [1:0] vfn, input logic [15:0] exp_out, input logic exp_err,
                          input int exp_busy);
        int cyc;
        a = va;
        b = vb;
        fn = vfn;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_result(name, exp_out, exp_err, exp_busy, 1'b0, cyc);
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{"add_ff_ff",   8'hFF, 8'hFF, 2'b00, 16'h01FE, 1'b0, 1};
        vecs[1]  = '{"sub_3_5",     8'h03, 8'h05, 2'b01, 16'hFFFE, 1'b0, 1};
        vecs[2]  = '{"mul_ff_ff",   8'hFF, 8'hFF, 2'b10, 16'hFE01, 1'b0, 8};
        vecs[3]  = '{"div_200_7",   8'd200, 8'd7, 2'b11, 16'h041C, 1'b0, 8};
        vecs[4]  = '{"div_by_zero", 8'h12, 8'h00, 2'b11, 16'hFFFF, 1'b1, 1};
        vecs[5]  = '{"add_0_0",     8'h00, 8'h00, 2'b00, 16'h0000, 1'b0, 1};
        vecs[6]  = '{"mul_d_b",     8'h0D, 8'h0B, 2'b10, 16'h008F, 1'b0, 8};
        vecs[7]  = '{"sub_80_1",    8'h80, 8'h01, 2'b01, 16'h007F, 1'b0, 1};
        vecs[8]  = '{"div_ff_1",    8'hFF, 8'h01, 2'b11, 16'h00FF, 1'b0, 8};
        vecs[9]  = '{"div_5_9",     8'h05, 8'h09, 2'b11, 16'h0500, 1'b0, 8};
        vecs[10] = '{"mul_0_ab",    8'h00, 8'hAB, 2'b10, 16'h0000, 1'b0, 8};
        vecs[11] = '{"sub_0_ff",    8'h00, 8'hFF, 2'b01, 16'hFF01, 1'b0, 1};
        vecs[12] = '{"add_80_80",   8'h80, 8'h80, 2'b00, 16'h0100, 1'b0, 1};

        // asynchronous reset, checked before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("reset out", 32'(out), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset err", 32'(err), 0);

        // release at a negedge; the first vector starts on the very next rising edge
        @(negedge clk);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 13; i++)
            run_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vfn,
                   vecs[i].exp_out, vecs[i].exp_err, vecs[i].exp_busy);

        // MUL with operands, opcode and start toggling throughout EXEC
        a = 8'hFF;
        b = 8'hFF;
        fn = 2'b10;
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_result("mul_toggle", 16'hFE01, 1'b0, 8, 1'b1, cyc);

        // start held high through DONE: accepted on the first IDLE edge
        a = 8'h01;
        b = 8'h02;
        fn = 2'b00;
        start = 1'b1;
        wait_result("held_start_add", 16'h0003, 1'b0, 1, 1'b0, cyc);
        chk("held_start latency", cyc, 2);
        start = 1'b0;
        @(negedge clk);

        // reset asserted after 4 EXEC cycles of a MUL
        a = 8'hFF;
        b = 8'hFF;
        fn = 2'b10;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midmul_reset out", 32'(out), 0);
        chk("midmul_reset busy", 32'(busy), 0);
        chk("midmul_reset done", 32'(done), 0);
        chk("midmul_reset err", 32'(err), 0);
        @(negedge clk);
        chk("midmul_reset no_done", 32'(done), 0);
        rst_n = 1'b1;
        run_op("add_after_reset", 8'h01, 8'h01, 2'b00, 16'h0002, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
